main_memory_arbiter: RTL and testbench

Sequences every access to the single-ported main memory and shares it between two requesters: the instruction-fetch path (read-only) and the load/store data path (read or write). It is a request/acknowledge arbiter with one transaction in flight at a time. It drives the memory's read_address, write_address, write_data and write_enable pins and returns read data to whichever requester owns the transaction. It replaces stage-based address muxing, so fetch and memory stages can request independently.

---
 rtl/main_memory_arbiter.sv | 143 ++++++++++++++
 tb/tb_main_memory_arbiter.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_arbiter.sv
// Arbiter for the single-ported main memory: fetch (read-only) and
// load/store data share it, one transaction in flight at a time.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_req/addr        fetch request, held until fetch_ack
//   fetch_ack             combinational accept (IDLE only)
//   fetch_rvalid/rdata    one-cycle response pulse, held data
//   data_req/we/addr/wdata load/store request, held until data_ack
//   data_ack              combinational accept (IDLE only)
//   data_rvalid/rdata     one-cycle load response pulse, held data
//   read_address, write_address, write_data, write_enable,
//   read_data             memory pins
//   busy                  transaction in progress
module main_memory_arbiter #(
    parameter int READ_LATENCY   = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic [31:0] read_address,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        write_enable,
    input  logic [31:0] read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LAT_LOAD  = 3'(READ_LATENCY - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_t      state;
    state_t      state_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        owner_q;   // 1 = data path owns the transaction
    logic [2:0]  lat_cnt;
    logic [3:0]  starve_cnt;
    logic        starved;
    logic        fetch_win;
    logic        data_win;

    // Fetch only beats data when data has had its full burst
    // while fetch was waiting.
    always_comb begin
        starved   = (starve_cnt == BURST_MAX);
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state == IDLE && !rst) begin
            fetch_win = fetch_req && (!data_req || starved);
            data_win  = data_req && !(fetch_req && starved);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (fetch_win || data_win) state_nx = ISSUE;
            ISSUE:   state_nx = we_q ? IDLE : WAIT;
            WAIT:    if (lat_cnt == 3'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        fetch_ack    = fetch_win;
        data_ack     = data_win;
        fetch_rvalid = (state == RESP) && !rst && !owner_q;
        data_rvalid  = (state == RESP) && !rst && owner_q;
        write_enable = (state == ISSUE) && we_q;
        busy         = (state != IDLE);
    end

    assign read_address  = addr_q;
    assign write_address = addr_q;
    assign write_data    = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            if (fetch_win) begin
                addr_q  <= fetch_addr;
                we_q    <= 1'b0;
                owner_q <= 1'b0;
            end else if (data_win) begin
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                we_q    <= data_we;
                owner_q <= 1'b1;
            end

            if (state == ISSUE && !we_q)
                lat_cnt <= LAT_LOAD;
            else if (state == WAIT && lat_cnt != 3'd0)
                lat_cnt <= lat_cnt - 3'd1;

            if (state == WAIT && lat_cnt == 3'd0) begin
                if (owner_q) data_rdata  <= read_data;
                else         fetch_rdata <= read_data;
            end

            if (!fetch_req || fetch_win)
                starve_cnt <= '0;
            else if (data_win && !starved)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: two instances (READ_LATENCY 1 and 3)
// each backed by a small pipelined memory model.
module tb_main_memory_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst          [2];
    logic        fetch_req    [2];
    logic [31:0] fetch_addr   [2];
    logic        fetch_ack    [2];
    logic        fetch_rvalid [2];
    logic [31:0] fetch_rdata  [2];
    logic        data_req     [2];
    logic        data_we      [2];
    logic [31:0] data_addr    [2];
    logic [31:0] data_wdata   [2];
    logic        data_ack     [2];
    logic        data_rvalid  [2];
    logic [31:0] data_rdata   [2];
    logic [31:0] read_address [2];
    logic [31:0] write_address[2];
    logic [31:0] write_data   [2];
    logic        write_enable [2];
    logic        busy         [2];

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] rd0;
    logic [31:0] s0, s1, s2;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    main_memory_arbiter #(.READ_LATENCY(1), .MAX_DATA_BURST(4)) u_l1 (
        .clk(clk), .rst(rst[0]),
        .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
        .fetch_ack(fetch_ack[0]), .fetch_rvalid(fetch_rvalid[0]),
        .fetch_rdata(fetch_rdata[0]),
        .data_req(data_req[0]), .data_we(data_we[0]),
        .data_addr(data_addr[0]), .data_wdata(data_wdata[0]),
        .data_ack(data_ack[0]), .data_rvalid(data_rvalid[0]),
        .data_rdata(data_rdata[0]),
        .read_address(read_address[0]),
        .write_address(write_address[0]),
        .write_data(write_data[0]),
        .write_enable(write_enable[0]),
        .read_data(rd0), .busy(busy[0])
    );

    main_memory_arbiter #(.READ_LATENCY(3), .MAX_DATA_BURST(4)) u_l3 (
        .clk(clk), .rst(rst[1]),
        .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
        .fetch_ack(fetch_ack[1]), .fetch_rvalid(fetch_rvalid[1]),
        .fetch_rdata(fetch_rdata[1]),
        .data_req(data_req[1]), .data_we(data_we[1]),
        .data_addr(data_addr[1]), .data_wdata(data_wdata[1]),
        .data_ack(data_ack[1]), .data_rvalid(data_rvalid[1]),
        .data_rdata(data_rdata[1]),
        .read_address(read_address[1]),
        .write_address(write_address[1]),
        .write_data(write_data[1]),
        .write_enable(write_enable[1]),
        .read_data(s2), .busy(busy[1])
    );

    // Memory models: word-indexed, contents 0x1000_0000+index,
    // word 4 (byte 0x10) holds 0xDEADBEEF.
    always @(posedge clk) begin
        if (rst[0]) begin
            for (int i = 0; i < 256; i++)
                mem0[i] <= (i == 4) ? 32'hDEADBEEF
                                    : 32'h1000_0000 + 32'(i);
        end else if (write_enable[0]) begin
            mem0[write_address[0][9:2]] <= write_data[0];
        end
        rd0 <= mem0[read_address[0][9:2]];
    end

    always @(posedge clk) begin
        if (rst[1]) begin
            for (int i = 0; i < 256; i++)
                mem1[i] <= 32'h1000_0000 + 32'(i);
        end else if (write_enable[1]) begin
            mem1[write_address[1][9:2]] <= write_data[1];
        end
        s0 <= mem1[read_address[1][9:2]];
        s1 <= s0;
        s2 <= s1;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input int d, input int lim, output int n);
        n = 0;
        do begin
            next();
            #1;
            n++;
        end while (!(fetch_rvalid[d] || data_rvalid[d]) && n < lim);
    endtask

    function automatic exp_t pop_exp();
        exp_t r;
        r.owner = 1'bx;
        r.val   = 'x;
        if (sb.size() > 0) r = sb.pop_front();
        return r;
    endfunction

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; fetch_req[d] = 1'b0; data_req[d] = 1'b0;
            data_we[d] = 1'b0; fetch_addr[d] = '0;
            data_addr[d] = '0; data_wdata[d] = '0;
        end
        next();
        next();
        next();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || write_enable[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctl[%0d]: busy=%b we=%b want 0 0",
                         d, busy[d], write_enable[d]);
            end
            checks++;
            if (fetch_rdata[d] !== 32'h0 || data_rdata[d] !== 32'h0) begin
                fails++;
                $display("FAIL reset_rdata[%0d]: %h %h want 0 0",
                         d, fetch_rdata[d], data_rdata[d]);
            end
            checks++;
            if ({fetch_ack[d], data_ack[d], fetch_rvalid[d],
                 data_rvalid[d]} !== 4'b0) begin
                fails++;
                $display("FAIL reset_hs[%0d]: acks/rvalids nonzero", d);
            end
            checks++;
            if (read_address[d] !== 32'h0 || write_data[d] !== 32'h0) begin
                fails++;
                $display("FAIL reset_mem[%0d]: ra=%h wd=%h want 0",
                         d, read_address[d], write_data[d]);
            end
        end
    endtask

    task automatic test_single_fetch();
        exp_t        e;
        int          n;
        logic [33:0] got, want;
        next();
        fetch_req[0] = 1'b1;
        fetch_addr[0] = 32'h10;
        #1;
        checks++;
        if (fetch_ack[0] !== 1'b1 || data_ack[0] !== 1'b0) begin
            fails++;
            $display("FAIL fetch_ack: fa=%b da=%b want 1 0",
                     fetch_ack[0], data_ack[0]);
        end
        sb.push_back('{1'b0, mem0[8'h04]});
        for (int c = 1; c <= 2; c++) begin
            next();
            fetch_req[0] = 1'b0;
            #1;
            checks++;
            if (read_address[0] !== 32'h10 || busy[0] !== 1'b1 ||
                fetch_rvalid[0] !== 1'b0) begin
                fails++;
                $display("FAIL fetch_c%0d: ra=%h busy=%b rv=%b",
                         c, read_address[0], busy[0], fetch_rvalid[0]);
            end
        end
        wait_rv(0, 4, n);
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL fetch_lat: rvalid at cycle %0d want 3", 2 + n);
        end
        e = pop_exp();
        got = {data_rvalid[0], fetch_rvalid[0],
               data_rvalid[0] ? data_rdata[0] : fetch_rdata[0]};
        want = {e.owner, !e.owner, e.val};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL fetch_resp: got %h want %h", got, want);
        end
        next();
        #1;
        checks++;
        if (fetch_rvalid[0] !== 1'b0 || fetch_rdata[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL fetch_hold: rv=%b rd=%h want 0 deadbeef",
                     fetch_rvalid[0], fetch_rdata[0]);
        end
    endtask

    task automatic test_store();
        exp_t        e;
        int          n;
        logic [33:0] got, want;
        next();
        data_req[0] = 1'b1; data_we[0] = 1'b1;
        data_addr[0] = 32'h40; data_wdata[0] = 32'h1234;
        #1;
        checks++;
        if (data_ack[0] !== 1'b1 || write_enable[0] !== 1'b0) begin
            fails++;
            $display("FAIL store_ack: ack=%b we=%b want 1 0",
                     data_ack[0], write_enable[0]);
        end
        next();
        data_req[0] = 1'b0;
        #1;
        checks++;
        if ({write_enable[0], write_address[0], write_data[0]} !==
            {1'b1, 32'h40, 32'h1234}) begin
            fails++;
            $display("FAIL store_issue: we=%b wa=%h wd=%h want 1 40 1234",
                     write_enable[0], write_address[0], write_data[0]);
        end
        for (int c = 2; c <= 3; c++) begin
            next();
            #1;
            checks++;
            if ({busy[0], write_enable[0], fetch_rvalid[0],
                 data_rvalid[0]} !== 4'b0) begin
                fails++;
                $display("FAIL store_c%0d: busy=%b we=%b rv=%b%b", c,
                         busy[0], write_enable[0], fetch_rvalid[0],
                         data_rvalid[0]);
            end
        end
        // read the stored word back through the data path
        next();
        data_req[0] = 1'b1; data_we[0] = 1'b0;
        #1;
        checks++;
        if (data_ack[0] !== 1'b1) begin
            fails++;
            $display("FAIL readback_ack: %b want 1", data_ack[0]);
        end
        sb.push_back('{1'b1, 32'h1234});
        next();
        data_req[0] = 1'b0;
        wait_rv(0, 6, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL readback_lat: rvalid at %0d want 3", 1 + n);
        end
        e = pop_exp();
        got = {data_rvalid[0], fetch_rvalid[0],
               data_rvalid[0] ? data_rdata[0] : fetch_rdata[0]};
        want = {e.owner, !e.owner, e.val};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL readback_resp: got %h want %h", got, want);
        end
    endtask

    task automatic test_simultaneous();
        exp_t        e;
        int          n;
        logic [33:0] got, want;
        next();
        next();
        fetch_req[0] = 1'b1; fetch_addr[0] = 32'h20;
        data_req[0] = 1'b1; data_we[0] = 1'b0; data_addr[0] = 32'h30;
        #1;
        checks++;
        if ({fetch_ack[0], data_ack[0]} !== 2'b01) begin
            fails++;
            $display("FAIL sim_c0: fa=%b da=%b want 0 1",
                     fetch_ack[0], data_ack[0]);
        end
        sb.push_back('{1'b1, mem0[8'h0C]});
        next();
        data_req[0] = 1'b0;
        #1;
        next();
        #1;
        checks++;
        if (fetch_ack[0] !== 1'b0) begin
            fails++;
            $display("FAIL sim_c2: fetch_ack=%b want 0", fetch_ack[0]);
        end
        next();
        #1;
        e = pop_exp();
        got = {data_rvalid[0], fetch_rvalid[0],
               data_rvalid[0] ? data_rdata[0] : fetch_rdata[0]};
        want = {e.owner, !e.owner, e.val};
        checks++;
        if (got !== want || fetch_ack[0] !== 1'b0) begin
            fails++;
            $display("FAIL sim_c3: got %h fa=%b want %h fa=0",
                     got, fetch_ack[0], want);
        end
        next();
        #1;
        checks++;
        if (fetch_ack[0] !== 1'b1) begin
            fails++;
            $display("FAIL sim_c4: fetch_ack=%b want 1", fetch_ack[0]);
        end
        sb.push_back('{1'b0, mem0[8'h08]});
        next();
        fetch_req[0] = 1'b0;
        wait_rv(0, 6, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL sim_flat: rvalid at %0d want 7", 5 + n);
        end
        e = pop_exp();
        got = {data_rvalid[0], fetch_rvalid[0],
               data_rvalid[0] ? data_rdata[0] : fetch_rdata[0]};
        want = {e.owner, !e.owner, e.val};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL sim_fresp: got %h want %h", got, want);
        end
    endtask

    task automatic test_starvation();
        exp_t        e;
        logic [33:0] got, want;
        logic [5:0]  grants;
        int          ng;
        logic        da, fa;
        grants = 'x;
        ng = 0;
        next();
        next();
        fetch_req[0] = 1'b1; fetch_addr[0] = 32'h50;
        data_req[0] = 1'b1; data_we[0] = 1'b1;
        data_addr[0] = 32'h60; data_wdata[0] = 32'hA0;
        for (int k = 0; k < 60 && ng < 6; k++) begin
            #1;
            da = data_ack[0];
            fa = fetch_ack[0];
            checks++;
            if (da === 1'b1 && fa === 1'b1) begin
                fails++;
                $display("FAIL starve_dual: both acks at step %0d", k);
            end
            if (fetch_rvalid[0] || data_rvalid[0]) begin
                e = pop_exp();
                got = {data_rvalid[0], fetch_rvalid[0],
                       data_rvalid[0] ? data_rdata[0] : fetch_rdata[0]};
                want = {e.owner, !e.owner, e.val};
                checks++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL starve_resp: got %h want %h", got, want);
                end
            end
            if (da === 1'b1) begin
                grants[ng] = 1'b1;
                ng++;
            end else if (fa === 1'b1) begin
                grants[ng] = 1'b0;
                ng++;
                sb.push_back('{1'b0, mem0[8'h14]});
            end
            next();
            if (da === 1'b1) data_wdata[0] = data_wdata[0] + 32'h1;
            if (fa === 1'b1) fetch_req[0] = 1'b0;
        end
        data_req[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (grants[i] !== (i != 4)) begin
                fails++;
                $display("FAIL starve_grant%0d: got %b want %b",
                         i, grants[i], (i != 4));
            end
        end
        next();
        next();
        #1;
        checks++;
        if (sb.size() !== 0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL starve_drain: pending=%0d busy=%b want 0 0",
                     sb.size(), busy[0]);
        end
        checks++;
        if (mem0[8'h18] !== 32'hA4) begin
            fails++;
            $display("FAIL starve_mem: got %h want a4", mem0[8'h18]);
        end
    endtask

    task automatic test_latency3();
        exp_t        e;
        logic [31:0] seen;
        logic [33:0] got, want;
        seen = 'x;
        next();
        data_req[1] = 1'b1; data_we[1] = 1'b0; data_addr[1] = 32'h80;
        #1;
        checks++;
        if (data_ack[1] !== 1'b1) begin
            fails++;
            $display("FAIL l3_ack: %b want 1", data_ack[1]);
        end
        sb.push_back('{1'b1, mem1[8'h20]});
        for (int c = 1; c <= 4; c++) begin
            next();
            data_req[1] = 1'b0;
            #1;
            checks++;
            if (read_address[1] !== 32'h80 || data_rvalid[1] !== 1'b0) begin
                fails++;
                $display("FAIL l3_c%0d: ra=%h rv=%b want 80 0",
                         c, read_address[1], data_rvalid[1]);
            end
            if (c == 4) seen = s2;
        end
        next();
        #1;
        e = pop_exp();
        got = {data_rvalid[1], fetch_rvalid[1],
               data_rvalid[1] ? data_rdata[1] : fetch_rdata[1]};
        want = {e.owner, !e.owner, e.val};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL l3_resp: got %h want %h", got, want);
        end
        checks++;
        if (data_rdata[1] !== seen) begin
            fails++;
            $display("FAIL l3_sample: rdata %h want c4 read_data %h",
                     data_rdata[1], seen);
        end
        next();
        #1;
        checks++;
        if (busy[1] !== 1'b0 || data_rvalid[1] !== 1'b0) begin
            fails++;
            $display("FAIL l3_done: busy=%b rv=%b want 0 0",
                     busy[1], data_rvalid[1]);
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t        e;
        int          n;
        logic [33:0] got, want;
        next();
        data_req[0] = 1'b1; data_we[0] = 1'b0; data_addr[0] = 32'h44;
        #1;
        checks++;
        if (data_ack[0] !== 1'b1) begin
            fails++;
            $display("FAIL rw_ack: %b want 1", data_ack[0]);
        end
        next();
        data_req[0] = 1'b0;
        next();
        rst[0] = 1'b1;
        #1;
        checks++;
        if (data_rvalid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL rw_c2: rv=%b busy=%b want 0 1",
                     data_rvalid[0], busy[0]);
        end
        next();
        rst[0] = 1'b0;
        fetch_req[0] = 1'b1; fetch_addr[0] = 32'h10;
        #1;
        checks++;
        if ({data_rvalid[0], busy[0], data_rdata[0]} !== 34'h0) begin
            fails++;
            $display("FAIL rw_c3: rv=%b busy=%b rd=%h want 0 0 0",
                     data_rvalid[0], busy[0], data_rdata[0]);
        end
        checks++;
        if (fetch_ack[0] !== 1'b1) begin
            fails++;
            $display("FAIL rw_fack: %b want 1", fetch_ack[0]);
        end
        sb.push_back('{1'b0, 32'hDEADBEEF});
        next();
        fetch_req[0] = 1'b0;
        wait_rv(0, 6, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL rw_flat: rvalid at %0d want 6", 4 + n);
        end
        e = pop_exp();
        got = {data_rvalid[0], fetch_rvalid[0],
               data_rvalid[0] ? data_rdata[0] : fetch_rdata[0]};
        want = {e.owner, !e.owner, e.val};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL rw_fresp: got %h want %h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_latency3();
        test_reset_in_wait();
        next();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
